// File: rtl/tx_trigger.sv
// Switch-driven transmit trigger: one-shot per press or auto-repeat while held.
// Define TRIG_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter on the switch.
module tx_trigger #(
  parameter int unsigned PULSE_LEN       = 100000,
  parameter int unsigned REPEAT_GAP      = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch,
  input  logic       mode,
  input  logic       tx_busy,
  output logic       transmit,
  output logic       active,
  output logic [7:0] pulse_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PULSE     = 3'd1,
    WAIT_BUSY = 3'd2,
    GAP       = 3'd3,
    HOLD      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(REPEAT_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       sw_q;
  logic       sw_prev_q, sw_prev_d;
  logic       armed_q, armed_d;
  logic       rise_c;

  // Arm the edge detector only once a genuine low level has passed the synchroniser,
  // so a switch held high through reset cannot trigger.
  always_comb begin
    sync1_d    = switch;
    sync2_d    = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    sw_prev_d  = sw_q;
    armed_d    = armed_q | (sync_vld_q[1] & ~sync2_q & ~sw_q);
  end

  assign rise_c = sw_q & ~sw_prev_q & armed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync_vld_q <= 2'b00;
      sw_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync_vld_q <= sync_vld_d;
      sw_prev_q  <= sw_prev_d;
      armed_q    <= armed_d;
    end
  end

`ifdef TRIG_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sw_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    sw_d     = sw_q;
    db_cnt_d = '0;
    if (sync2_q != sw_q) begin
      if (db_cnt_q == DB_LAST) sw_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sw_q     <= sw_d;
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  assign sw_q = sync2_q;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             transmit_q, transmit_d;
  logic             active_q, active_d;
  logic [7:0]       pulse_count_q, pulse_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rise_c) state_d = PULSE;
      PULSE:     if (cnt_q == PULSE_LAST) state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_busy) state_d = mode_q ? GAP : HOLD;
      GAP:       if (cnt_q == GAP_LAST) state_d = sw_q ? PULSE : IDLE;
      HOLD:      if (!sw_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter runs only in timed states and restarts on every state change.
  always_comb begin
    cnt_d         = '0;
    mode_d        = mode_q;
    pulse_count_d = pulse_count_q;
    transmit_d    = (state_d == PULSE);
    active_d      = (state_d != IDLE);
    if ((state_d == state_q) && ((state_q == PULSE) || (state_q == GAP)))
      cnt_d = cnt_q + CNT_ONE;
    if ((state_d == PULSE) && (state_q != PULSE)) begin
      pulse_count_d = pulse_count_q + 8'd1;
      mode_d        = mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      transmit_q    <= 1'b0;
      active_q      <= 1'b0;
      pulse_count_q <= 8'd0;
    end else begin
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      transmit_q    <= transmit_d;
      active_q      <= active_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign transmit    = transmit_q;
  assign active      = active_q;
  assign pulse_count = pulse_count_q;

endmodule
